// File: rtl/i_type_if.sv
// Instruction/register-read bundle for the i_type load/store core.
// The master drives the decoded instruction fields; the slave (i_type) returns
// the current contents of the rs and rt registers.
interface i_type_if;
  logic [5:0]  OpCode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] datars;
  logic [31:0] datart;

  modport master (
    output OpCode,
    output rs,
    output rt,
    output imm,
    input  datars,
    input  datart
  );

  modport slave (
    input  OpCode,
    input  rs,
    input  rt,
    input  imm,
    output datars,
    output datart
  );
endinterface

// File: rtl/i_type.sv
// i_type: single-cycle LW/SW datapath with a 32x32 register file and a
// MEM_WORDS x 32 word-addressed data memory. Effective address is
// reg[rs] + sign_extend(imm), wrapped to the memory depth.
// Optional feature: define I_TYPE_ADDI_EN to enable ADDI (opcode 6'b001000).
module i_type #(
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [5:0]  LW_OP     = 6'b100011,
  parameter logic [5:0]  SW_OP     = 6'b101011
) (
  input logic     clk,
  input logic     reset,
  i_type_if.slave bus
);

  localparam int unsigned AddrW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
`ifdef I_TYPE_ADDI_EN
  localparam logic [5:0] AddiOp = 6'b001000;
`endif

  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [31:0]      mem_q  [MEM_WORDS];
  logic [31:0]      mem_d  [MEM_WORDS];

  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic [31:0]      imm_sext;
  logic [31:0]      ea;
  logic [AddrW-1:0] mem_idx;

  // Operand read and effective-address generation; R0 always reads as zero.
  always_comb begin
    rs_val   = (bus.rs == 5'd0) ? 32'd0 : regs_q[bus.rs];
    rt_val   = (bus.rt == 5'd0) ? 32'd0 : regs_q[bus.rt];
    imm_sext = {{16{bus.imm[15]}}, bus.imm};
    ea       = rs_val + imm_sext;
    mem_idx  = ea[AddrW-1:0];
  end

  // Next-state for register file and memory; all operands are pre-edge values.
  always_comb begin
    regs_d = regs_q;
    mem_d  = mem_q;
    if (bus.OpCode == LW_OP) begin
      if (bus.rt != 5'd0) begin
        regs_d[bus.rt] = mem_q[mem_idx];
      end
    end else if (bus.OpCode == SW_OP) begin
      mem_d[mem_idx] = rt_val;
`ifdef I_TYPE_ADDI_EN
    end else if (bus.OpCode == AddiOp) begin
      if (bus.rt != 5'd0) begin
        regs_d[bus.rt] = ea;
      end
`endif
    end
  end

  // State update; reset loads reg[i] = i and mem[k] = 1000 + k, overriding any instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'(i);
      end
      for (int k = 0; k < int'(MEM_WORDS); k++) begin
        mem_q[k] <= 32'(1000 + k);
      end
    end else begin
      regs_q <= regs_d;
      mem_q  <= mem_d;
    end
  end

  // Register read ports are purely combinational.
  always_comb begin
    bus.datars = rs_val;
    bus.datart = rt_val;
  end

endmodule

// File: tb/tb_i_type.sv
// Self-checking bench for i_type: directed scenarios followed by randomized
// instructions compared against an array-based architectural model.
module tb_i_type;

  localparam int unsigned MemWords = 64;
  localparam logic [5:0]  LwOp     = 6'b100011;
  localparam logic [5:0]  SwOp     = 6'b101011;
  localparam logic [5:0]  AddiOp   = 6'b001000;

  logic clk;
  logic reset;

  i_type_if bus ();

  i_type #(
    .MEM_WORDS(MemWords),
    .LW_OP    (LwOp),
    .SW_OP    (SwOp)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [MemWords];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = i;
    for (int k = 0; k < int'(MemWords); k++) m_mem[k] = 1000 + k;
  endtask

  // Apply one instruction for one clock edge, advance the model, check read ports.
  task automatic step(input string tag, input logic [5:0] op, input logic [4:0] a,
                      input logic [4:0] t, input logic [15:0] im, input logic rst);
    logic [31:0] ea;
    int unsigned idx;
    logic [31:0] store_val;
    bus.OpCode = op;
    bus.rs     = a;
    bus.rt     = t;
    bus.imm    = im;
    reset      = rst;
    if (rst) begin
      model_reset();
    end else begin
      ea        = m_reg[a] + {{16{im[15]}}, im};
      idx       = ea % MemWords;
      store_val = m_reg[t];
      if (op == LwOp) begin
        if (t != 0) m_reg[t] = m_mem[idx];
      end else if (op == SwOp) begin
        m_mem[idx] = store_val;
      end
`ifdef I_TYPE_ADDI_EN
      else if (op == AddiOp) begin
        if (t != 0) m_reg[t] = ea;
      end
`endif
    end
    @(posedge clk);
    #1;
    check({tag, ".datars"}, bus.datars, m_reg[a]);
    check({tag, ".datart"}, bus.datart, m_reg[t]);
  endtask

  // Combinational read of a register pair without a clock edge.
  task automatic peek(input string tag, input logic [4:0] a, input logic [4:0] t);
    bus.OpCode = 6'b000000;
    bus.rs     = a;
    bus.rt     = t;
    #1;
    check({tag, ".rs"}, bus.datars, m_reg[a]);
    check({tag, ".rt"}, bus.datart, m_reg[t]);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] r;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.OpCode = 6'b000000;
    bus.rs = 5'd0;
    bus.rt = 5'd0;
    bus.imm = 16'd0;
    model_reset();

    // Reset state, with an SW competing against reset.
    step("rst0", 6'b000000, 5'd0, 5'd0, 16'd0, 1'b1);
    step("rst_sw", SwOp, 5'd3, 5'd9, 16'd7, 1'b1);
    for (int i = 0; i < 32; i++) begin
      peek("rst_regs", 5'(i), 5'(31 - i));
      check("rst_idx", bus.datars, 32'(i));
    end
    step("rst_mem10", LwOp, 5'd10, 5'd7, 16'd0, 1'b0);
    check("rst_mem10_const", bus.datart, 32'd1010);
    step("rst_again", 6'b000000, 5'd0, 5'd0, 16'd0, 1'b1);

    // Directed LW/SW sequence.
    step("lw_r2", LwOp, 5'd3, 5'd2, 16'd5, 1'b0);
    check("lw_r2_rs", bus.datars, 32'd3);
    check("lw_r2_rt", bus.datart, 32'd1008);
    step("sw_r9", SwOp, 5'd3, 5'd9, 16'd7, 1'b0);
    check("sw_r9_rt", bus.datart, 32'd9);
    step("lw_r7", LwOp, 5'd10, 5'd7, 16'd0, 1'b0);
    check("lw_r7_rt", bus.datart, 32'd9);
    step("lw_neg", LwOp, 5'd3, 5'd4, 16'hFFFF, 1'b0);
    check("lw_neg_rt", bus.datart, 32'd1002);
    step("lw_wrap", LwOp, 5'd0, 5'd5, 16'd70, 1'b0);
    check("lw_wrap_rt", bus.datart, 32'd1006);
    step("lw_r0", LwOp, 5'd3, 5'd0, 16'd5, 1'b0);
    check("lw_r0_rt", bus.datart, 32'd0);
    step("nop", 6'b000000, 5'd31, 5'd17, 16'h1234, 1'b0);
    step("sw_same", SwOp, 5'd3, 5'd3, 16'd1, 1'b0);
    step("lw_same", LwOp, 5'd0, 5'd11, 16'd4, 1'b0);
    check("lw_same_rt", bus.datart, 32'd3);
    step("addi", AddiOp, 5'd3, 5'd6, 16'hFFFC, 1'b0);
`ifdef I_TYPE_ADDI_EN
    check("addi_rt", bus.datart, 32'hFFFF_FFFF);
`else
    check("addi_rt", bus.datart, 32'd6);
`endif

    // Randomized instructions, occasional mid-sequence reset.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: op = LwOp;
        3, 4, 5: op = SwOp;
        6:       op = AddiOp;
        7:       op = 6'b000000;
        default: op = 6'($urandom);
      endcase
      step("rand", op, 5'($urandom), 5'($urandom), 16'($urandom),
           ($urandom_range(0, 39) == 0));
    end

    // Sweep final memory and registers through the read ports.
    for (int i = 0; i < 32; i++) peek("final_regs", 5'(i), 5'(i));
    for (int k = 0; k < int'(MemWords); k++) begin
      step("final_mem", LwOp, 5'd0, 5'd1, 16'(k), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i_type.md
I_TYPE -- requirements
Module: i_type

Interface
REQ-001 SHALL expose ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: OpCode  input  6  instruction opcode field.
REQ-004 SHALL expose: rs  input  5  base register index.
REQ-005 SHALL expose: rt  input  5  source/destination register index.
REQ-006 SHALL expose: imm  input  16  signed 16-bit offset.
REQ-007 SHALL expose: datars  output  32  current contents of register rs.
REQ-008 SHALL expose: datart  output  32  current contents of register rt.
REQ-009 SHALL have parameters: MEM_WORDS, default 64, data memory depth in 32-bit words (power of 2); LW_OP, default 6'b100011; SW_OP, default 6'b101011.

Function
REQ-010 SHALL contain a 32x32-bit register file and a MEM_WORDS x 32-bit word-addressed data memory.
REQ-011 SHALL compute EA = reg[rs] + sign_extend(imm) in 32-bit arithmetic, overflow discarded.
REQ-012 SHALL index memory with EA modulo MEM_WORDS (low log2(MEM_WORDS) bits; wrap-around, no fault).
REQ-013 SHALL, for OpCode == LW_OP, write mem[EA] into reg[rt] at the rising clk edge.
REQ-014 SHALL, for OpCode == SW_OP, write reg[rt] into mem[EA] at the rising clk edge.
REQ-015 SHALL treat every other OpCode as a no-op (no state change).
REQ-016 SHALL hard-wire R0 to zero: writes to R0 discarded, reads return 0.
REQ-017 SHALL drive datars/datart combinationally from the register file; a value written at an edge appears on the outputs immediately after that edge (one-cycle latency for LW).
REQ-018 SHALL use pre-edge register values for EA and store data, also when rs == rt.
REQ-019 SHALL perform at most one state update per cycle; no handshake, a new instruction is accepted every cycle.

Reset
REQ-020 SHALL, while reset is high at a rising edge, set reg[i] = i for i = 0..31 and mem[k] = 1000 + k for all k.
REQ-021 SHALL give reset priority over any instruction in the same cycle; the instruction is discarded.
REQ-022 SHALL restore the full reset state if reset is asserted mid-sequence; outputs reflect the reset values immediately after that edge.

Configuration
REQ-023 SHALL support macro I_TYPE_ADDI_EN: when defined, OpCode 6'b001000 (ADDI) writes reg[rs] + sign_extend(imm) into reg[rt] at the edge (R0 rule applies).
REQ-024 SHALL, when I_TYPE_ADDI_EN is undefined, treat 6'b001000 as a no-op.

Verification
REQ-025 Reset, then LW R2,5(R3) (EA 8), one edge -> datars=3, datart=1008.
REQ-026 Then SW R9,7(R3) (EA 10), one edge -> mem[10]=9, datars=3, datart=9; then LW R7,0(R10) -> datart=9.
REQ-027 LW R4,-1(R3) (imm 16'hFFFF, EA 2) -> datart=1002; LW R5,70(R0) with MEM_WORDS=64 -> wraps to index 6, datart=1006.
REQ-028 LW R0,5(R3) -> datart stays 0; OpCode 6'b000000 with any fields -> no register/memory change.
REQ-029 SW R9,7(R3) issued with reset high -> mem[10] remains 1010; registers all equal their index.
REQ-030 With I_TYPE_ADDI_EN: ADDI R6,R3,-4 -> datart = 32'hFFFFFFFF; without it -> datart stays 6.
